// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream sink between N sources.
// Define AXIS_ARB_STATS_EN to add per-source accepted-packet counters on pkt_count.
module axis_rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 256
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [N*W-1:0]       s_tdata,
  input  logic [N-1:0]         s_tvalid,
  input  logic [N-1:0]         s_tlast,
  output logic [N-1:0]         s_tready,
  output logic [W-1:0]         m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [N*32-1:0]      pkt_count
`endif
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  logic          found;
  logic          xfer_last;
  logic [W-1:0]  src_data [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign src_data[i] = s_tdata[i*W +: W];
  end

  // First requester at or after last_q+1, wrapping modulo N.
  always_comb begin
    sel   = last_q;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last_q) + k) % N);
      if (!found && s_tvalid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|s_tvalid) begin
          state_d = LOCK;
          grant_d = sel;
          last_d  = sel;
        end
      end
      LOCK: begin
        if (xfer_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake is gated by aresetn so nothing is accepted on the reset edge.
  always_comb begin
    m_tdata  = src_data[grant_q];
    m_tlast  = s_tlast[grant_q];
    m_tvalid = 1'b0;
    s_tready = '0;
    if (state_q == LOCK && aresetn) begin
      m_tvalid          = s_tvalid[grant_q];
      s_tready[grant_q] = m_tready;
    end
  end

  assign xfer_last = m_tvalid && m_tready && m_tlast;

  // last_q resets to N-1 so source 0 holds first priority.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant_valid = (state_q == LOCK);
  assign grant_idx   = grant_q;

`ifdef AXIS_ARB_STATS_EN
  logic [31:0] cnt_q [N];

  // One count per accepted tlast beat; wraps naturally at 2^32.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (xfer_last) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_cnt
    assign pkt_count[i*32 +: 32] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (N=4, W=256).
`timescale 1ns/1ps
module tb_axis_rr_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 256;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [N*W-1:0] s_tdata;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tlast;
  logic [N-1:0]   s_tready;
  logic [W-1:0]   m_tdata;
  logic           m_tvalid;
  logic           m_tlast;
  logic           m_tready;
  logic           grant_valid;
  logic [1:0]     grant_idx;
`ifdef AXIS_ARB_STATS_EN
  logic [N*32-1:0] pkt_count;
`endif

  axis_rr_arbiter #(.N(N), .W(W)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
`ifdef AXIS_ARB_STATS_EN
    ,
    .pkt_count   (pkt_count)
`endif
  );

  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  // Source model: remaining beats, beats sent, packet length, and a valid-drop hold.
  int           rem  [N];
  int           sent [N];
  int           plen [N];
  bit           hold [N];
  logic [N-1:0] acc;
  logic [W-1:0] exp_d;

  task automatic clr_model();
    for (int i = 0; i < N; i++) begin
      rem[i]  = 0;
      sent[i] = 0;
      plen[i] = 1;
      hold[i] = 1'b0;
    end
  endtask

  task automatic settle();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]       = (rem[i] > 0) && !hold[i];
      s_tlast[i]        = ((sent[i] + 1) % plen[i]) == 0;
      s_tdata[i*W +: W] = W'(i * 1000 + sent[i]);
    end
    #1;
  endtask

  task automatic tick();
    for (int i = 0; i < N; i++) acc[i] = s_tvalid[i] & s_tready[i];
    @(posedge aclk);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        rem[i]  = rem[i] - 1;
        sent[i] = sent[i] + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    m_tready = 1'b1;
    clr_model();
    for (int i = 0; i < N; i++) rem[i] = 1;
    settle();
    tick();
    settle();
    checks++;
    if (grant_valid !== 1'b0) begin
      failures++; $display("FAIL reset_grant_valid got=%0b exp=0", grant_valid);
    end
    checks++;
    if (grant_idx !== 2'd0) begin
      failures++; $display("FAIL reset_grant_idx got=%0d exp=0", grant_idx);
    end
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++; $display("FAIL reset_m_tvalid got=%0b exp=0", m_tvalid);
    end
    checks++;
    if (s_tready !== 4'b0000) begin
      failures++; $display("FAIL reset_s_tready got=%b exp=0000", s_tready);
    end
`ifdef AXIS_ARB_STATS_EN
    checks++;
    if (pkt_count !== '0) begin
      failures++; $display("FAIL reset_pkt_count got=%0h exp=0", pkt_count);
    end
`endif
    clr_model();
    aresetn = 1'b1;
    settle();
    tick();
  endtask

  task automatic test_rotation();
    int order [5] = '{0, 1, 2, 3, 0};
    int p;
    int ph;
    clr_model();
    for (int i = 0; i < N; i++) begin
      plen[i] = 2;
      rem[i]  = 2;
    end
    rem[0] = 4;
    for (int c = 0; c < 15; c++) begin
      settle();
      p  = c / 3;
      ph = c % 3;
      checks++;
      if (grant_valid !== (ph != 0)) begin
        failures++; $display("FAIL rot_grant_valid c=%0d got=%0b exp=%0b", c, grant_valid, ph != 0);
      end
      if (ph != 0) begin
        exp_d = W'(order[p] * 1000 + ((p == 4) ? 2 : 0) + ph - 1);
        checks++;
        if (grant_idx !== 2'(order[p])) begin
          failures++; $display("FAIL rot_grant_idx c=%0d got=%0d exp=%0d", c, grant_idx, order[p]);
        end
        checks++;
        if (m_tvalid !== 1'b1) begin
          failures++; $display("FAIL rot_m_tvalid c=%0d got=%0b exp=1", c, m_tvalid);
        end
        checks++;
        if (m_tdata !== exp_d) begin
          failures++; $display("FAIL rot_m_tdata c=%0d got=%0h exp=%0h", c, m_tdata, exp_d);
        end
        checks++;
        if (m_tlast !== (ph == 2)) begin
          failures++; $display("FAIL rot_m_tlast c=%0d got=%0b exp=%0b", c, m_tlast, ph == 2);
        end
      end
      tick();
    end
    settle();
    checks++;
    if (grant_valid !== 1'b0 || rem[0] != 0 || rem[3] != 0) begin
      failures++; $display("FAIL rot_drain got_gv=%0b rem0=%0d rem3=%0d exp=0/0/0", grant_valid, rem[0], rem[3]);
    end
  endtask

  task automatic test_packet_lock();
    bit exp_gv;
    bit exp_mv;
    int exp_g;
    clr_model();
    plen[1] = 5; rem[1] = 5;
    plen[2] = 2; rem[2] = 2;
    for (int c = 0; c < 13; c++) begin
      hold[1] = (c >= 3 && c <= 5);
      settle();
      exp_gv = !(c == 0 || c == 9 || c == 12);
      exp_g  = (c <= 8) ? 1 : 2;
      exp_mv = exp_gv && !(c >= 3 && c <= 5);
      checks++;
      if (grant_valid !== exp_gv) begin
        failures++; $display("FAIL lock_grant_valid c=%0d got=%0b exp=%0b", c, grant_valid, exp_gv);
      end
      if (exp_gv) begin
        checks++;
        if (grant_idx !== 2'(exp_g)) begin
          failures++; $display("FAIL lock_grant_idx c=%0d got=%0d exp=%0d", c, grant_idx, exp_g);
        end
        checks++;
        if (m_tvalid !== exp_mv) begin
          failures++; $display("FAIL lock_m_tvalid c=%0d got=%0b exp=%0b", c, m_tvalid, exp_mv);
        end
      end
      if (c >= 1 && c <= 8) begin
        checks++;
        if (s_tready[2] !== 1'b0) begin
          failures++; $display("FAIL lock_src2_ready c=%0d got=%0b exp=0", c, s_tready[2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit exp_gv;
    clr_model();
    plen[0] = 3; rem[0] = 3;
    for (int c = 0; c < 9; c++) begin
      m_tready = !(c >= 2 && c <= 5);
      settle();
      exp_gv = (c >= 1 && c <= 7);
      checks++;
      if (grant_valid !== exp_gv) begin
        failures++; $display("FAIL bp_grant_valid c=%0d got=%0b exp=%0b", c, grant_valid, exp_gv);
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== W'(1)) begin
          failures++; $display("FAIL bp_stable c=%0d got_v=%0b got_d=%0h exp_v=1 exp_d=1", c, m_tvalid, m_tdata);
        end
        checks++;
        if (s_tready !== 4'b0000) begin
          failures++; $display("FAIL bp_s_tready c=%0d got=%b exp=0000", c, s_tready);
        end
      end
      tick();
    end
    m_tready = 1'b1;
  endtask

  task automatic test_skip_idle();
    clr_model();
    plen[3] = 1; rem[3] = 3;
    for (int c = 0; c < 7; c++) begin
      settle();
      checks++;
      if (grant_valid !== c[0]) begin
        failures++; $display("FAIL skip_grant_valid c=%0d got=%0b exp=%0b", c, grant_valid, c[0]);
      end
      if (c[0]) begin
        checks++;
        if (grant_idx !== 2'd3 || m_tlast !== 1'b1) begin
          failures++; $display("FAIL skip_grant c=%0d got_idx=%0d got_last=%0b exp=3/1", c, grant_idx, m_tlast);
        end
        checks++;
        if (s_tready !== 4'b1000) begin
          failures++; $display("FAIL skip_s_tready c=%0d got=%b exp=1000", c, s_tready);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    clr_model();
    plen[2] = 4; rem[2] = 4;
    settle();
    tick();
    settle();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd2) begin
      failures++; $display("FAIL rmid_lock got_gv=%0b got_idx=%0d exp=1/2", grant_valid, grant_idx);
    end
    tick();
    aresetn = 1'b0;
    settle();
    checks++;
    if (s_tready !== 4'b0000) begin
      failures++; $display("FAIL rmid_ready_in_reset got=%b exp=0000", s_tready);
    end
    tick();
    aresetn = 1'b1;
    clr_model();
    rem[0] = 1;
    rem[2] = 1;
    settle();
    checks++;
    if (grant_valid !== 1'b0 || m_tvalid !== 1'b0) begin
      failures++; $display("FAIL rmid_after_reset got_gv=%0b got_mv=%0b exp=0/0", grant_valid, m_tvalid);
    end
    tick();
    settle();
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd0) begin
      failures++; $display("FAIL rmid_src0_wins got_gv=%0b got_idx=%0d exp=1/0", grant_valid, grant_idx);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      settle();
    end
    checks++;
    if (rem[0] != 0 || rem[2] != 0) begin
      failures++; $display("FAIL rmid_drain got_rem0=%0d got_rem2=%0d exp=0/0", rem[0], rem[2]);
    end
  endtask

`ifdef AXIS_ARB_STATS_EN
  task automatic test_stats();
    aresetn = 1'b0;
    clr_model();
    settle();
    tick();
    aresetn = 1'b1;
    rem[0] = 3;
    rem[1] = 1;
    for (int c = 0; c < 12; c++) begin
      settle();
      tick();
    end
    settle();
    checks++;
    if (pkt_count[0 +: 32] !== 32'd3) begin
      failures++; $display("FAIL stats_cnt0 got=%0d exp=3", pkt_count[0 +: 32]);
    end
    checks++;
    if (pkt_count[32 +: 32] !== 32'd1) begin
      failures++; $display("FAIL stats_cnt1 got=%0d exp=1", pkt_count[32 +: 32]);
    end
    checks++;
    if (pkt_count[64 +: 64] !== 64'd0) begin
      failures++; $display("FAIL stats_cnt23 got=%0h exp=0", pkt_count[64 +: 64]);
    end
    dut.cnt_q[3] = 32'hFFFF_FFFF;
    rem[3] = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      tick();
    end
    settle();
    checks++;
    if (pkt_count[96 +: 32] !== 32'd0) begin
      failures++; $display("FAIL stats_wrap got=%0h exp=0", pkt_count[96 +: 32]);
    end
    checks++;
    if (pkt_count[0 +: 32] !== 32'd3) begin
      failures++; $display("FAIL stats_cnt0_hold got=%0d exp=3", pkt_count[0 +: 32]);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    aresetn  = 1'b0;
    m_tready = 1'b1;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    test_reset();
    test_rotation();
    test_packet_lock();
    test_backpressure();
    test_skip_idle();
    test_reset_mid();
`ifdef AXIS_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
